// File: rtl/det_share_arb.sv
// det_share_arb: round-robin arbiter feeding one shared "BAZ" sequence matcher with per-channel saved progress.
// Optional per-channel idle timeout is compiled in with `define DET_SHARE_TIMEOUT_EN.
module det_share_arb #(
  parameter int            NCH     = 4,
  parameter int            CW      = 8,
  parameter logic [CW-1:0] PAT0    = 8'h42,
  parameter logic [CW-1:0] PAT1    = 8'h41,
  parameter logic [CW-1:0] PAT2    = 8'h5A,
  parameter int            TMO_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*CW-1:0]       req_char,
  output logic [NCH-1:0]          req_ready,
  input  logic [NCH-1:0]          ch_clr,
  output logic                    hit_valid,
  output logic [$clog2(NCH)-1:0]  hit_ch,
  output logic [15:0]             hit_total
);

  localparam int CHW = $clog2(NCH);

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2} state_t;

  state_t          r_state     [NCH];
  state_t          w_state_nxt [NCH];
  logic [CHW-1:0]  r_ptr;
  logic [CHW-1:0]  w_gidx;
  logic            w_any;
  logic [NCH-1:0]  w_elig;
  logic [CW-1:0]   w_gchar;
  logic            w_hit;
  logic            r_hit_valid_p1;
  logic [CHW-1:0]  r_hit_ch_p1;
  logic [15:0]     r_hit_total_p1;

`ifdef DET_SHARE_TIMEOUT_EN
  localparam int IW = $clog2(TMO_CYC + 1);
  logic [IW-1:0] r_idle     [NCH];
  logic [IW-1:0] w_idle_nxt [NCH];
`endif

  // Fallback to S1 on PAT0 is exact because the three pattern characters are distinct.
  function automatic state_t f_step(input state_t s, input logic [CW-1:0] c);
    state_t n;
    n = S0;
    if (c == PAT0)
      n = S1;
    else if (s == S1 && c == PAT1)
      n = S2;
    return n;
  endfunction

  function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    logic [CHW-1:0] idx;
    idx    = '0;
    w_elig = req_valid & ~ch_clr;
    w_any  = 1'b0;
    w_gidx = '0;
    // Walk downward so the candidate nearest the pointer is written last and wins.
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = CHW'((int'(r_ptr) + k) % NCH);
      if (w_elig[idx]) begin
        w_any  = 1'b1;
        w_gidx = idx;
      end
    end
  end

  assign req_ready = (rstn && w_any) ? (NCH'(1) << w_gidx) : '0;
  assign w_gchar   = req_char[int'(w_gidx)*CW +: CW];

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
`ifdef DET_SHARE_TIMEOUT_EN
      w_idle_nxt[i] = '0;
`endif
      if (ch_clr[i]) begin
        w_state_nxt[i] = S0;
      end else if (w_any && int'(w_gidx) == i) begin
        w_state_nxt[i] = f_step(r_state[i], w_gchar);
        if (r_state[i] == S2 && w_gchar == PAT2)
          w_hit = 1'b1;
      end
`ifdef DET_SHARE_TIMEOUT_EN
      else if (r_state[i] != S0) begin
        if (r_idle[i] == IW'(TMO_CYC - 1))
          w_state_nxt[i] = S0;
        else
          w_idle_nxt[i] = r_idle[i] + IW'(1);
      end
`endif
    end
  end

`ifndef DET_SHARE_TIMEOUT_EN
  // Timeout disabled: partial progress is held indefinitely and TMO_CYC only gates this empty check.
  if (TMO_CYC < 1) begin : g_tmo_unused
  end
`endif

  // Stage p1: match state, pointer and hit reporting registered at the accept edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= S0;
`ifdef DET_SHARE_TIMEOUT_EN
        r_idle[i]  <= '0;
`endif
      end
      r_ptr          <= '0;
      r_hit_valid_p1 <= 1'b0;
      r_hit_ch_p1    <= '0;
      r_hit_total_p1 <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
`ifdef DET_SHARE_TIMEOUT_EN
        r_idle[i]  <= w_idle_nxt[i];
`endif
      end
      if (w_any)
        r_ptr <= (w_gidx == CHW'(NCH - 1)) ? '0 : w_gidx + CHW'(1);
      r_hit_valid_p1 <= w_hit;
      if (w_hit)
        r_hit_ch_p1 <= w_gidx;
      r_hit_total_p1 <= w_hit ? f_sat_inc(r_hit_total_p1) : r_hit_total_p1;
    end
  end

  assign hit_valid = r_hit_valid_p1;
  assign hit_ch    = r_hit_ch_p1;
  assign hit_total = r_hit_total_p1;

endmodule

// File: doc/det_share_arb.md
Name: det_share_arb

Overview:
- Shares one "BAZ"-style 3-character sequence matcher among NCH character streams, such as Smart-Room keypads or UART receivers.
- A round-robin arbiter accepts at most one character per cycle from one stream.
- Each stream keeps its own saved match progress, so interleaved streams are matched independently.
- Detections are reported with the originating channel and counted in a global saturating total.

Parameters:
- NCH, 4: number of requesting channels, 2..8.
- CW, 8: character width in bits (ASCII).
- PAT0, 8'h42: first pattern character, "B".
- PAT1, 8'h41: second pattern character, "A".
- PAT2, 8'h5A: third pattern character, "Z".
- TMO_CYC, 16: idle timeout in cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- req_valid  in  NCH  per-channel character-valid.
- req_char  in  NCH*CW  per-channel character; channel i occupies bits [i*CW +: CW].
- req_ready  out  NCH  one-hot grant; the character is consumed when req_valid[i] and req_ready[i] are both 1.
- ch_clr  in  NCH  per-channel clear of the saved match progress.
- hit_valid  out  1  one-cycle pulse marking a completed pattern.
- hit_ch  out  $clog2(NCH)  channel that completed the pattern; valid while hit_valid is 1.
- hit_total  out  16  count of all hits, saturating at 16'hFFFF.

Behaviour:
- Reset (rstn=0 at a posedge):
  - all channel states go to S0; RR pointer goes to 0.
  - hit_valid=0, hit_ch=0, hit_total=0.
  - req_ready=0 throughout the reset cycle.
- Eligibility: channel i is eligible when req_valid[i]=1 and ch_clr[i]=0.
- Arbitration:
  - req_ready is combinational.
  - The grant goes to the first eligible channel, searching from ptr upward and wrapping modulo NCH.
  - At most one bit of req_ready is set.
  - req_ready=0 when no channel is eligible.
- Pointer update: after a grant to channel g, ptr becomes (g+1) mod NCH. With no grant, ptr holds.
- Per-channel state is 2 bits: S0 = no progress, S1 = PAT0 seen, S2 = PAT0,PAT1 seen.
- State transitions, applied to the granted channel only, using its character c:
  - S0: c==PAT0 -> S1; otherwise stay in S0.
  - S1: c==PAT1 -> S2; c==PAT0 -> S1; otherwise -> S0.
  - S2: c==PAT2 -> S0 and a hit; c==PAT0 -> S1; otherwise -> S0.
- The fallback rule is exact only for patterns whose three characters are distinct. Patterns with repeated characters are unsupported.
- Non-granted channels keep their state.
- Hit timing:
  - Accepting PAT2 in S2 at edge N sets hit_valid=1 and hit_ch=g from edge N until edge N+1.
  - hit_total increments at edge N unless it is already FFFF.
  - Latency is one cycle from the accept edge.
- ch_clr[i]=1 at an edge forces channel i to S0. In that cycle the channel is not granted, and its character is not consumed.
- hit_valid is 0 in every cycle without a hit. Back-to-back hits from different channels in consecutive cycles produce consecutive pulses.
- Reset in mid-operation discards all partial progress and the pending hit pulse.

Optional Feature:
- Macro: DET_SHARE_TIMEOUT_EN.
- When defined:
  - each channel has an idle counter, cleared whenever the channel is granted or its state is S0.
  - the counter increments each cycle while the channel is in S1 or S2 without a grant.
  - when the count reaches TMO_CYC-1, the channel state goes to S0 at that edge.
  - a grant in the same cycle takes precedence over the timeout.
- When undefined: no counters are built, and partial progress is held indefinitely.

Test Plan:
1. Reset, then only ch0 valid with chars "B","N","K","M","B","A","Z" on successive accepts -> exactly one hit_valid pulse with hit_ch=0, one cycle after "Z" is accepted; hit_total=1.
2. ch0 sends "B","A","A","A","Z" -> no hit (the second "A" returns S2 to S0); hit_total unchanged.
3. ch0 and ch1 both always valid; ch0 sends "B","A","Z" and ch1 sends "X","B","A","Z" -> grants alternate 0,1,0,1,...; ch0 hits first, then ch1; hit_ch=0 then 1 on separate pulses.
4. All 4 channels valid with ptr=2 after reset and some traffic -> grant order is 2,3,0,1; idle cycles leave ptr unchanged.
5. ch2 in S2 (after "B","A"), then ch_clr[2]=1 while req_valid[2]=1 with char "Z" -> req_ready[2]=0, no hit; a later "Z" alone also gives no hit.
6. Force hit_total=FFFF through repeated hits (or preload in simulation), one more hit -> hit_valid pulses and hit_total stays FFFF. With DET_SHARE_TIMEOUT_EN and TMO_CYC=16: "B","A", then 16 idle cycles, then "Z" -> no hit.
